serial_alu: RTL

- Multi-cycle execution unit on the consumer side of the 4-bit ALU control code produced by the ALU decode stage.
- Accepts one operation per handshake.
- Add/sub/compare/logic ops complete in one cycle; shifts are done iteratively, one bit position per cycle, to save area.
- Sits between register read and writeback. Also supplies the zero flag used for branch resolution.

---
 rtl/serial_alu.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu
// Description : Multi-cycle ALU that takes one operation per valid/ready
//               handshake. Add/sub/compare/logic ops finish in one cycle.
//               Shifts move one bit position per cycle. The unit also drives
//               a registered zero flag for branch resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         ALUctrl_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               zero_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // funct3 values of the ALU control code
  localparam logic [2:0] c_f3_addsub = 3'b000;
  localparam logic [2:0] c_f3_sll    = 3'b001;
  localparam logic [2:0] c_f3_slt    = 3'b010;
  localparam logic [2:0] c_f3_sltu   = 3'b011;
  localparam logic [2:0] c_f3_xor    = 3'b100;
  localparam logic [2:0] c_f3_sr     = 3'b101;
  localparam logic [2:0] c_f3_or     = 3'b110;
  localparam logic [2:0] c_f3_and    = 3'b111;

  // Shift kinds held while the iterative shift runs
  localparam logic [1:0] c_k_sll = 2'd0;
  localparam logic [1:0] c_k_srl = 2'd1;
  localparam logic [1:0] c_k_sra = 2'd2;

  localparam logic [SHAMT_W-1:0] c_cnt_one = SHAMT_W'(1);

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_work;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [1:0]           r_kind;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero;

  logic [2:0]           w_f3;
  logic                 w_alt;
  logic                 w_is_shift;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [1:0]           w_kind;
  logic [WIDTH-1:0]     w_alu_res;
  logic [WIDTH-1:0]     w_step;
  logic                 w_accept;

  // bit0 of the code (funct7_5) only matters for sub and sra; every other
  // odd code falls onto its even neighbour because only w_f3 is decoded there
  assign w_f3       = ALUctrl_i[3:1];
  assign w_alt      = ALUctrl_i[0];
  assign w_is_shift = (w_f3 == c_f3_sll) || (w_f3 == c_f3_sr);
  assign w_shamt    = op_b_i[SHAMT_W-1:0];
  assign w_kind     = (w_f3 == c_f3_sll) ? c_k_sll : (w_alt ? c_k_sra : c_k_srl);
  assign w_accept   = (r_state == IDLE) && valid_i;

  assign ready_o  = (r_state == IDLE);
  assign valid_o  = (r_state == DONE);
  assign result_o = r_result;
  assign zero_o   = r_zero;

  // Single-cycle result for the non-shift operations
  always_comb begin
    w_alu_res = '0;
    case (w_f3)
      c_f3_addsub: w_alu_res = w_alt ? (op_a_i - op_b_i) : (op_a_i + op_b_i);
      c_f3_slt:    w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      c_f3_sltu:   w_alu_res = {{(WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
      c_f3_xor:    w_alu_res = op_a_i ^ op_b_i;
      c_f3_or:     w_alu_res = op_a_i | op_b_i;
      c_f3_and:    w_alu_res = op_a_i & op_b_i;
      default:     w_alu_res = '0;
    endcase
  end

  // One-bit shift step of the working register
  always_comb begin
    w_step = r_work;
    case (r_kind)
      c_k_sll: w_step = {r_work[WIDTH-2:0], 1'b0};
      c_k_srl: w_step = {1'b0, r_work[WIDTH-1:1]};
      c_k_sra: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_step = r_work;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a zero-length shift skips SHIFT entirely
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_next_state = SHIFT;
          end else begin
            w_next_state = DONE;
          end
        end
      end
      SHIFT: begin
        if (r_cnt == c_cnt_one) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture at acceptance, shift iteratively, load result on entry to DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_work   <= '0;
      r_cnt    <= '0;
      r_kind   <= c_k_sll;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      if (w_accept) begin
        if (w_is_shift) begin
          r_work <= op_a_i;
          r_cnt  <= w_shamt;
          r_kind <= w_kind;
          if (w_shamt == '0) begin
            r_result <= op_a_i;
            r_zero   <= (op_a_i == '0);
          end
        end else begin
          r_result <= w_alu_res;
          r_zero   <= (w_alu_res == '0);
        end
      end else if (r_state == SHIFT) begin
        r_work <= w_step;
        r_cnt  <= r_cnt - c_cnt_one;
        if (r_cnt == c_cnt_one) begin
          r_result <= w_step;
          r_zero   <= (w_step == '0);
        end
      end
    end
  end

endmodule
`default_nettype wire
